// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: ROM address/data, decode stall, execute redirect and the IF/ID register outputs.
interface fetch_stage_if #(
   parameter int unsigned WIDTH = 24
);
   logic [WIDTH-1:0] imem_addr;
   logic [WIDTH-1:0] imem_rd;
   logic             stall_i;
   logic             redirect_i;
   logic [WIDTH-1:0] redirect_pc_i;
   logic [WIDTH-1:0] instr_o;
   logic [WIDTH-1:0] pc_o;
   logic             valid_o;
   logic             halted_o;

   modport master (
      output imem_addr,
      input  imem_rd,
      input  stall_i,
      input  redirect_i,
      input  redirect_pc_i,
      output instr_o,
      output pc_o,
      output valid_o,
      output halted_o
   );

   modport slave (
      input  imem_addr,
      output imem_rd,
      output stall_i,
      output redirect_i,
      output redirect_pc_i,
      input  instr_o,
      input  pc_o,
      input  valid_o,
      input  halted_o
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the ROM and fills the IF/ID register.
// Optional HALT-opcode detection is compiled in with `define FETCH_HALT_EN.
module fetch_stage #(
   parameter int unsigned      WIDTH    = 24,
   parameter int unsigned      AMOUNT   = 256,
   parameter int unsigned      RESET_PC = 0,
   parameter logic [WIDTH-1:0] HALT_OP  = {WIDTH{1'b1}}
) (
   input  logic           clk,
   input  logic           rst_n,
   fetch_stage_if.master  fif
);

   localparam int unsigned AW = $clog2(AMOUNT);

`ifdef FETCH_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   typedef enum logic {RUN, HALT} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    pc_q, pc_d;
   logic [WIDTH-1:0] if_instr_q, if_instr_d;
   logic [WIDTH-1:0] if_pc_q, if_pc_d;
   logic             if_valid_q, if_valid_d;
   logic             halt_hit_c;

   // PC bits above the ROM index are always zero
   assign fif.imem_addr = WIDTH'(pc_q);
   assign halt_hit_c    = HALT_EN && (fif.imem_rd == HALT_OP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         pc_q       <= AW'(RESET_PC);
         if_instr_q <= '0;
         if_pc_q    <= '0;
         if_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
         if_valid_q <= if_valid_d;
      end
   end

   // Priority: redirect > stall > halt bubble > advance
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      if_valid_d = if_valid_q;
      if (fif.redirect_i) begin
         state_d    = RUN;
         pc_d       = fif.redirect_pc_i[AW-1:0];
         if_instr_d = '0;
         if_pc_d    = '0;
         if_valid_d = 1'b0;
      end else if (!fif.stall_i) begin
         if (state_q == HALT) begin
            if_valid_d = 1'b0;
         end else begin
            if_instr_d = fif.imem_rd;
            if_pc_d    = WIDTH'(pc_q);
            if_valid_d = 1'b1;
            // the HALT word itself is delivered; the PC parks on it
            if (halt_hit_c) begin
               state_d = HALT;
            end else begin
               pc_d = pc_q + AW'(1);
            end
         end
      end
   end

   assign fif.instr_o = if_instr_q;
   assign fif.pc_o    = if_pc_q;
   assign fif.valid_o = if_valid_q;

`ifdef FETCH_HALT_EN
   assign fif.halted_o = (state_q == HALT);
`else
   assign fif.halted_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations,
// then randomized stall/redirect traffic against a behavioural model.
module tb_fetch_stage;

   localparam int unsigned WIDTH  = 24;
   localparam int unsigned AMOUNT = 256;
   localparam int          HALTW  = 24'hFFFFFF;

`ifdef FETCH_HALT_EN
   localparam bit HALT_ON = 1'b1;
`else
   localparam bit HALT_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   logic [WIDTH-1:0] rom [AMOUNT];

   int n_chk = 0;
   int n_err = 0;

   // behavioural model state
   int m_pc, m_instr, m_pcr, m_valid, m_halted;

   fetch_stage_if #(.WIDTH(WIDTH)) fif ();

   fetch_stage #(
      .WIDTH   (WIDTH),
      .AMOUNT  (AMOUNT),
      .RESET_PC(0),
      .HALT_OP (24'hFFFFFF)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .fif  (fif)
   );

   always #5 clk = ~clk;

   assign fif.imem_rd = rom[fif.imem_addr[7:0]];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: fetch rules stated as plain integer arithmetic
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc = 0; m_instr = 0; m_pcr = 0; m_valid = 0; m_halted = 0;
      end else if (fif.redirect_i) begin
         m_pc = int'(fif.redirect_pc_i) % AMOUNT;
         m_instr = 0; m_pcr = 0; m_valid = 0; m_halted = 0;
      end else if (fif.stall_i) begin
         // everything holds
      end else if (m_halted != 0) begin
         m_valid = 0;
      end else begin
         m_instr = int'(rom[m_pc]);
         m_pcr   = m_pc;
         m_valid = 1;
         if (HALT_ON && m_instr == HALTW) m_halted = 1;
         else m_pc = (m_pc + 1) % AMOUNT;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      chk("cmp_addr",   int'(fif.imem_addr), m_pc);
      chk("cmp_valid",  int'(fif.valid_o),   m_valid);
      chk("cmp_instr",  int'(fif.instr_o),   m_instr);
      chk("cmp_pc",     int'(fif.pc_o),      m_pcr);
      chk("cmp_halted", int'(fif.halted_o),  m_halted);
   end

   task automatic redirect_to(input int target);
      fif.redirect_i    = 1'b1;
      fif.redirect_pc_i = WIDTH'(target);
      @(negedge clk);
      fif.redirect_i    = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < AMOUNT; i++) rom[i] = WIDTH'(i + 'h100);
      rst_n = 1'b0;
      fif.stall_i = 1'b0;
      fif.redirect_i = 1'b0;
      fif.redirect_pc_i = '0;

      repeat (2) @(negedge clk);
      chk("rst_valid", int'(fif.valid_o), 0);
      chk("rst_addr",  int'(fif.imem_addr), 0);
      chk("rst_instr", int'(fif.instr_o), 0);
      rst_n = 1'b1;

      // sequential fetch from reset
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("seq_instr", int'(fif.instr_o), 'h100 + k);
         chk("seq_pc",    int'(fif.pc_o), k);
         chk("seq_valid", int'(fif.valid_o), 1);
      end

      // stall at PC=5
      fif.stall_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_instr", int'(fif.instr_o), 'h104);
         chk("stall_addr",  int'(fif.imem_addr), 5);
      end
      fif.stall_i = 1'b0;
      @(negedge clk);
      chk("unstall_instr", int'(fif.instr_o), 'h105);
      chk("unstall_pc",    int'(fif.pc_o), 5);
      @(negedge clk);
      chk("pc7_addr", int'(fif.imem_addr), 7);

      // redirect together with stall
      fif.stall_i = 1'b1;
      redirect_to('h40);
      chk("rds_valid", int'(fif.valid_o), 0);
      chk("rds_addr",  int'(fif.imem_addr), 'h40);
      @(negedge clk);
      chk("rds_hold_valid", int'(fif.valid_o), 0);
      chk("rds_hold_addr",  int'(fif.imem_addr), 'h40);
      fif.stall_i = 1'b0;
      @(negedge clk);
      chk("rds_target", int'(fif.instr_o), 'h140);
      chk("rds_tvalid", int'(fif.valid_o), 1);

      // wrap-around
      redirect_to(250);
      chk("wrap_bubble", int'(fif.valid_o), 0);
      repeat (6) @(negedge clk);
      chk("wrap_255", int'(fif.pc_o), 255);
      @(negedge clk);
      chk("wrap_0_pc",    int'(fif.pc_o), 0);
      chk("wrap_0_instr", int'(fif.instr_o), 'h100);
      redirect_to('h105);
      chk("wrap_mod_addr", int'(fif.imem_addr), 5);
      @(negedge clk);
      chk("wrap_mod_instr", int'(fif.instr_o), 'h105);
      chk("wrap_mod_pc",    int'(fif.pc_o), 5);

      // HALT opcode at address 3
      rom[3] = 24'hFFFFFF;
      redirect_to(0);
      repeat (4) @(negedge clk);
      chk("halt_word",  int'(fif.instr_o), HALTW);
      chk("halt_wvld",  int'(fif.valid_o), 1);
`ifdef FETCH_HALT_EN
      @(negedge clk);
      chk("halt_valid",  int'(fif.valid_o), 0);
      chk("halt_flag",   int'(fif.halted_o), 1);
      chk("halt_addr",   int'(fif.imem_addr), 3);
      @(negedge clk);
      chk("halt_frozen", int'(fif.imem_addr), 3);
      redirect_to('h10);
      chk("unhalt_flag", int'(fif.halted_o), 0);
      @(negedge clk);
      chk("unhalt_instr", int'(fif.instr_o), 'h110);
`else
      @(negedge clk);
      chk("nohalt_pc",    int'(fif.pc_o), 4);
      chk("nohalt_instr", int'(fif.instr_o), 'h104);
      chk("nohalt_flag",  int'(fif.halted_o), 0);
`endif

      // async reset pulse at PC=20
      redirect_to(20);
      chk("pre_rst_addr", int'(fif.imem_addr), 20);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_addr",  int'(fif.imem_addr), 0);
      chk("arst_valid", int'(fif.valid_o), 0);
      chk("arst_instr", int'(fif.instr_o), 0);
      chk("arst_pc",    int'(fif.pc_o), 0);
      chk("arst_halt",  int'(fif.halted_o), 0);
      #4 rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("arst_restart_instr", int'(fif.instr_o), 'h100);
      chk("arst_restart_pc",    int'(fif.pc_o), 0);

      // randomized traffic against the model
      for (int i = 0; i < AMOUNT; i++)
         rom[i] = ($urandom_range(0, 15) == 0) ? 24'hFFFFFF : WIDTH'($urandom);
      for (int c = 0; c < 3000; c++) begin
         fif.stall_i       = ($urandom_range(0, 3) == 0);
         fif.redirect_i    = ($urandom_range(0, 9) == 0);
         fif.redirect_pc_i = WIDTH'($urandom);
         @(negedge clk);
      end
      fif.stall_i = 1'b0;
      fif.redirect_i = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly upstream of the instruction ROM (`instMem`) and downstream consumer of its read data. It owns the program counter, drives the ROM address combinationally, and registers the returned instruction with its PC into the IF/ID pipeline register. It handles decode-stage stalls and execute-stage redirects (branches and jumps). It optionally detects a HALT opcode and stops fetching.

## Interface
- `WIDTH`, 24, instruction width and PC/address width; matches the ROM's `WIDTH`.
- `AMOUNT`, 256, ROM depth in words; must be a power of two. The PC indexes the low log2(AMOUNT) bits.
- `RESET_PC`, 0, PC value loaded on reset; must be < AMOUNT.
- `HALT_OP`, 24'hFFFFFF, instruction encoding treated as HALT; used only with `FETCH_HALT_EN`.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  WIDTH  ROM address, equal to the current PC. Combinational from the PC register.
- `imem_rd`  in  WIDTH  ROM read data. Combinational, valid in the same cycle as `imem_addr`.
- `stall_i`  in  1  decode cannot accept; hold PC and the IF/ID register.
- `redirect_i`  in  1  branch or jump taken; reload the PC.
- `redirect_pc_i`  in  WIDTH  target PC; sampled only when `redirect_i`=1.
- `instr_o`  out  WIDTH  registered instruction (IF/ID).
- `pc_o`  out  WIDTH  registered PC of `instr_o`.
- `valid_o`  out  1  `instr_o`/`pc_o` hold a real instruction.
- `halted_o`  out  1  fetch is halted. Constant 0 without `FETCH_HALT_EN`.

## Operation
- States: RUN, HALT. HALT is reachable only with `FETCH_HALT_EN`.
- PC is word-addressed. Next sequential PC = (PC+1) mod AMOUNT, so AMOUNT-1 wraps to 0. PC bits above log2(AMOUNT) are always 0.
- Per-edge priority in RUN: redirect > stall > advance.
  - **Redirect:** PC <= `redirect_pc_i` mod AMOUNT. IF/ID is flushed (`valid_o`<=0, `instr_o`<=0, `pc_o`<=0). This applies even when `stall_i`=1.
  - **Stall** (no redirect): PC, `instr_o`, `pc_o` and `valid_o` all hold.
  - **Advance:** `instr_o`<=`imem_rd`, `pc_o`<=PC, `valid_o`<=1, PC<=next sequential PC.
- HALT detection (macro on): on an advance edge where `imem_rd`==`HALT_OP`:
  - The HALT word is captured normally (`valid_o`=1).
  - PC is not incremented.
  - State goes to HALT.
- In HALT:
  - Without redirect: PC frozen. If `stall_i`=1, IF/ID holds. If `stall_i`=0, `valid_o`<=0 (bubbles).
  - With redirect: same as RUN redirect, plus state goes to RUN and `halted_o`<=0.
- `halted_o` is a registered output, 1 exactly while in HALT.

## Timing
- Reset values: PC=RESET_PC (so `imem_addr`=RESET_PC), `instr_o`=0, `pc_o`=0, `valid_o`=0, `halted_o`=0, state RUN.
- Reset asserted mid-operation clears everything immediately, asynchronously. After release, fetch resumes from RESET_PC.
- Fetch latency is 1 cycle: PC presented in cycle n, then `instr_o`=ROM[PC] and `valid_o`=1 after edge n (if no stall or redirect).
- Throughput is one instruction per cycle when not stalled.
- Redirect penalty: redirect sampled at edge n produces one bubble after edge n. The target instruction appears after edge n+1.
- A redirect to the current PC is legal: it flushes and refetches.
- A redirect during stall flushes. The stall then holds the bubble and the new PC.

## Configuration
- `FETCH_HALT_EN` defined: the HALT state, `HALT_OP` comparison and `halted_o` logic are compiled in.
- Not defined: no halt detection. `HALT_OP` is fetched as an ordinary instruction. `halted_o` is tied to 0. Only the RUN state exists.

## Test plan
- **Reset/sequential:** ROM[i]=i+0x100, release `rst_n` with no stall. Expect cycle k: `instr_o`=0x100+k, `pc_o`=k, `valid_o`=1. Expect `valid_o`=0 before the first edge.
- **Stall:** assert `stall_i` for 3 cycles at PC=5. Expect `instr_o`=ROM[4] and `imem_addr`=5 held. Expect ROM[5] on the first edge after release.
- **Redirect vs stall:** at PC=7, assert `redirect_i`=1, `redirect_pc_i`=0x40 and `stall_i`=1 together. Expect `valid_o`=0 next cycle, `imem_addr`=0x40, and `instr_o`=ROM[0x40] one cycle after stall drops.
- **Wrap-around:** run to PC=255. Expect `pc_o`=255 then `pc_o`=0. Redirect to 0x1_05 yields PC=0x05.
- **HALT (macro on):** ROM[3]=0xFFFFFF. Expect `instr_o`=0xFFFFFF with `valid_o`=1, then `valid_o`=0, `halted_o`=1, `imem_addr`=3 frozen. Redirect to 0x10: `halted_o`=0 and ROM[0x10] fetched. With the macro off, fetching continues through PC=4.
- **Async reset mid-run:** pulse `rst_n` low for half a cycle at PC=20. Expect all outputs at reset values immediately and fetch restarting at RESET_PC.
